// File: rtl/slc3_mem_ctrl.sv
// SLC-3 memory/IO access sequencer: valid/ready request port, SRAM wait states,
// memory-mapped switches/hex at IO_ADDR, one-cycle response pulse.
module slc3_mem_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 2,
  parameter logic [ADDR_W-1:0] IO_ADDR = 16'hFFFF,
  parameter int NUM_HEX     = 4,
  parameter int SW_W        = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 rsp_valid,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic [ADDR_W-1:0]    sram_addr,
  output logic [DATA_W-1:0]    sram_wdata,
  input  logic [DATA_W-1:0]    sram_rdata,
  output logic                 sram_oe,
  output logic                 sram_we,
  input  logic [SW_W-1:0]      switches,
  output logic [4*NUM_HEX-1:0] hex_out
);

  localparam int HEX_W = 4 * NUM_HEX;
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                oe_q, oe_d;
  logic                swe_q, swe_d;
  logic                rsp_q, rsp_d;
  logic [HEX_W-1:0]    hex_q, hex_d;
  logic [SW_W-1:0]     sw_meta_q, sw_sync_q;
  logic [DATA_W-1:0]   sw_ext;
  logic                accept;

  generate
    if (SW_W >= DATA_W) begin : g_sw_trunc
      assign sw_ext = sw_sync_q[DATA_W-1:0];
    end else begin : g_sw_zext
      assign sw_ext = {{(DATA_W-SW_W){1'b0}}, sw_sync_q};
    end
  endgenerate

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    oe_d    = oe_q;
    swe_d   = swe_q;
    rsp_d   = 1'b0;
    hex_d   = hex_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_addr == IO_ADDR) begin
            if (req_we) hex_d = req_wdata[HEX_W-1:0];
            else        rdata_d = sw_ext;
            rsp_d   = 1'b1;
            state_d = RESP;
          end else begin
            addr_d  = req_addr;
            wdata_d = req_wdata;
            we_d    = req_we;
            cnt_d   = CNT_W'(WAIT_STATES);
            oe_d    = ~req_we;
            swe_d   = req_we;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (!we_q) rdata_d = sram_rdata;
          oe_d    = 1'b0;
          swe_d   = 1'b0;
          rsp_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are flops with async clear so a mid-access reset drops them at once.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      oe_q      <= 1'b0;
      swe_q     <= 1'b0;
      rsp_q     <= 1'b0;
      hex_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      oe_q      <= oe_d;
      swe_q     <= swe_d;
      rsp_q     <= rsp_d;
      hex_q     <= hex_d;
      sw_meta_q <= switches;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign rsp_valid  = rsp_q;
  assign rsp_rdata  = rdata_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign sram_oe    = oe_q;
  assign sram_we    = swe_q;
  assign hex_out    = hex_q;

endmodule

// File: tb/tb_slc3_mem_ctrl.sv
// Directed bench for slc3_mem_ctrl: WAIT_STATES=2 instance plus a
// WAIT_STATES=0 instance for the zero-wait timing.
module tb_slc3_mem_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;

  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata, sram_addr, sram_wdata, sram_rdata;
  logic        sram_oe, sram_we;
  logic [15:0] switches, hex_out;

  logic        req_valid_b, req_ready_b, req_we_b;
  logic [15:0] req_addr_b, req_wdata_b;
  logic        rsp_valid_b;
  logic [15:0] rsp_rdata_b, sram_addr_b, sram_wdata_b, sram_rdata_b;
  logic        sram_oe_b, sram_we_b;
  logic [15:0] switches_b, hex_out_b;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  slc3_mem_ctrl #(.WAIT_STATES(2)) u_dut (
    .Clk(Clk), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_oe(sram_oe), .sram_we(sram_we),
    .switches(switches), .hex_out(hex_out)
  );

  slc3_mem_ctrl #(.WAIT_STATES(0)) u_dut_ws0 (
    .Clk(Clk), .Reset(Reset),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
    .sram_addr(sram_addr_b), .sram_wdata(sram_wdata_b),
    .sram_rdata(sram_rdata_b), .sram_oe(sram_oe_b), .sram_we(sram_we_b),
    .switches(switches_b), .hex_out(hex_out_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One request on the WS=2 instance; idx 1 is the sample after the accept edge.
  task automatic do_op(input logic we, input logic [15:0] a,
                       input logic [15:0] d, output int lat,
                       output int oe_n, output int we_n,
                       output int bad, output logic rdy1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
    rdy1 = req_ready;
    lat  = -1;
    oe_n = 0;
    we_n = 0;
    bad  = 0;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      if (i > 1) tick();
      if (sram_oe) oe_n++;
      if (sram_we) we_n++;
      if (sram_oe && sram_we) bad++;
      if ((sram_oe || sram_we) &&
          (sram_addr !== a || (we && sram_wdata !== d))) bad++;
      if (rsp_valid) lat = i;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, oe_n, we_n, bad, nrsp, nbad, nrsp_b, noe_b;
    int   pos [3];
    logic rdy1;

    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
    sram_rdata = 0; switches = 0;
    req_valid_b = 0; req_we_b = 0; req_addr_b = 0; req_wdata_b = 0;
    sram_rdata_b = 0; switches_b = 0;

    #12;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_sram_addr", sram_addr, 0);
    chk("rst_sram_oe", sram_oe, 0);
    chk("rst_sram_we", sram_we, 0);
    chk("rst_hex", hex_out, 0);
    Reset = 1'b1;
    tick();
    chk("rst_ready", req_ready, 1);

    // 1: SRAM read
    sram_rdata = 16'hBEEF;
    do_op(1'b0, 16'h0010, 16'h0000, lat, oe_n, we_n, bad, rdy1);
    chk("t1_ready_drop", rdy1, 0);
    chk("t1_oe_cycles", oe_n, 3);
    chk("t1_we_cycles", we_n, 0);
    chk("t1_stable", bad, 0);
    chk("t1_latency", lat, 4);
    chk("t1_rdata", rsp_rdata, 16'hBEEF);
    tick();
    chk("t1_ready_back", req_ready, 1);
    chk("t1_rsp_single", rsp_valid, 0);

    // 2: SRAM write leaves rsp_rdata alone
    sram_rdata = 16'h5555;
    do_op(1'b1, 16'h0020, 16'h1234, lat, oe_n, we_n, bad, rdy1);
    chk("t2_we_cycles", we_n, 3);
    chk("t2_oe_cycles", oe_n, 0);
    chk("t2_stable", bad, 0);
    chk("t2_latency", lat, 4);
    chk("t2_rdata_hold", rsp_rdata, 16'hBEEF);
    tick();

    // 3: IO write then IO read
    do_op(1'b1, 16'hFFFF, 16'hCAFE, lat, oe_n, we_n, bad, rdy1);
    chk("t3_hex", hex_out, 16'hCAFE);
    chk("t3_latency", lat, 1);
    chk("t3_no_strobe", oe_n + we_n, 0);
    chk("t3_addr_hold", sram_addr, 16'h0020);
    tick();
    switches = 16'h00A5;
    tick(); tick(); tick();
    do_op(1'b0, 16'hFFFF, 16'h0000, lat, oe_n, we_n, bad, rdy1);
    chk("t3_sw_latency", lat, 1);
    chk("t3_sw_rdata", rsp_rdata, 16'h00A5);
    chk("t3_sw_no_strobe", oe_n + we_n, 0);
    tick();

    // IO back-to-back: responses every 2 cycles
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'hFFFF;
    tick();
    nrsp = 0;
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) tick();
      if (rsp_valid) nrsp++;
    end
    chk("t3_io_b2b", nrsp, 3);
    req_valid = 1'b0;
    tick(); tick();

    // 4: request held during ACCESS is ignored until ready
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010;
    sram_rdata = 16'h1111;
    tick();
    req_addr = 16'h0030;
    nrsp = 0; nbad = 0;
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) tick();
      if (rsp_valid) nrsp++;
      if (sram_oe && sram_addr !== 16'h0010) nbad++;
    end
    chk("t4_one_rsp", nrsp, 1);
    chk("t4_addr_kept", nbad, 0);
    chk("t4_rdata1", rsp_rdata, 16'h1111);
    chk("t4_ready_back", req_ready, 1);
    sram_rdata = 16'h2222;
    tick();
    chk("t4_second_accept", req_ready, 0);
    chk("t4_second_addr", sram_addr, 16'h0030);
    req_valid = 1'b0;
    lat = -1;
    for (int i = 2; i <= 12 && lat < 0; i++) begin
      tick();
      if (rsp_valid) lat = i;
    end
    chk("t4_second_lat", lat, 4);
    chk("t4_rdata2", rsp_rdata, 16'h2222);
    tick();

    // 5: reset mid-ACCESS
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0040;
    tick();
    req_valid = 1'b0;
    chk("t5_oe_pre", sram_oe, 1);
    #2;
    Reset = 1'b0;
    #1;
    chk("t5_oe_async", sram_oe, 0);
    chk("t5_we_async", sram_we, 0);
    chk("t5_hex_clr", hex_out, 0);
    #1;
    Reset = 1'b1;
    nrsp = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid) nrsp++;
    end
    chk("t5_no_rsp", nrsp, 0);
    chk("t5_ready", req_ready, 1);
    chk("t5_hex_after", hex_out, 0);

    // 6: WAIT_STATES=0, back-to-back reads every 3 cycles
    req_valid_b = 1'b1; req_we_b = 1'b0; req_addr_b = 16'h0050;
    sram_rdata_b = 16'h7777;
    tick();
    nrsp_b = 0; noe_b = 0;
    pos[0] = 0; pos[1] = 0; pos[2] = 0;
    for (int i = 1; i <= 9; i++) begin
      if (i > 1) tick();
      if (sram_oe_b) noe_b++;
      if (rsp_valid_b) begin
        if (nrsp_b < 3) pos[nrsp_b] = i;
        nrsp_b++;
      end
    end
    req_valid_b = 1'b0;
    chk("t6_first_lat", pos[0], 2);
    chk("t6_rsp_count", nrsp_b, 3);
    chk("t6_oe_cycles", noe_b, 3);
    chk("t6_period_a", pos[1] - pos[0], 3);
    chk("t6_period_b", pos[2] - pos[1], 3);
    chk("t6_rdata", rsp_rdata_b, 16'h7777);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
